// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS memory-access stage: op encodings,
// FSM state type and small decode helpers.
package mips_mem_pkg;

    localparam logic [2:0] OP_LB  = 3'b000;
    localparam logic [2:0] OP_LH  = 3'b001;
    localparam logic [2:0] OP_LW  = 3'b010;
    localparam logic [2:0] OP_SB  = 3'b011;
    localparam logic [2:0] OP_LBU = 3'b100;
    localparam logic [2:0] OP_LHU = 3'b101;
    localparam logic [2:0] OP_SH  = 3'b110;
    localparam logic [2:0] OP_SW  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WRITE
    } state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } size_t;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic size_t access_size(input logic [2:0] op);
        size_t sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SIZE_HALF;
            default:              sz = SIZE_WORD;
        endcase
        return sz;
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        logic bad;
        case (access_size(op))
            SIZE_HALF: bad = addr_lo[0];
            SIZE_WORD: bad = |addr_lo;
            default:   bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: extracts and extends load lanes and
// merges sub-word store data into a read word. Purely combinational.
module mem_lane_align
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2:0]            op,
    input  logic [1:0]            addr_lo,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [15:0]           store_data,
    output logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] merged
);

    logic [4:0]  byte_lsb;
    logic [4:0]  half_lsb;
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic        sign_ext;

    assign byte_lsb = {addr_lo, 3'b000};
    assign half_lsb = {addr_lo[1], 4'b0000};
    assign lane_b   = rdata[byte_lsb +: 8];
    assign lane_h   = rdata[half_lsb +: 16];
    // LB/LH have op[2] clear; LBU/LHU set it.
    assign sign_ext = !op[2];

    // Select the load lane and build the read-modify-write word.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        load_val = rdata;
        merged   = rdata;
        case (access_size(op))
            SIZE_BYTE: begin
                load_val = {{24{sign_ext & lane_b[7]}}, lane_b};
                merged[byte_lsb +: 8] = store_data[7:0];
            end
            SIZE_HALF: begin
                load_val = {{16{sign_ext & lane_h[15]}}, lane_h};
                merged[half_lsb +: 16] = store_data;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MIPS memory-access stage: accepts byte-addressed load/store requests and
// turns them into word accesses on an async-read/sync-write data memory.
// Sub-word stores are done as read (ACCESS) then write (WRITE).
module mem_access_stage
    import mips_mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_ADDR_WIDTH = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [2:0]                 i_op,
    input  logic [31:0]                i_addr,
    input  logic [DATA_WIDTH-1:0]      i_wdata,
    input  logic [4:0]                 i_rd,
    output logic                       o_wb_valid,
    output logic [DATA_WIDTH-1:0]      o_wb_data,
    output logic [4:0]                 o_wb_rd,
    output logic                       o_done,
    output logic                       o_misalign,
    output logic [DATA_ADDR_WIDTH-1:0] o_mem_addr,
    output logic                       o_mem_w_en,
    output logic [DATA_WIDTH-1:0]      o_mem_din,
    input  logic [DATA_WIDTH-1:0]      i_mem_dout
);

    state_t                state;
    state_t                state_next;

    logic [2:0]            req_op;
    logic [31:0]           req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [4:0]            req_rd;
    logic [DATA_WIDTH-1:0] merged_q;

    logic                  accept;
    logic                  fault;
    logic                  req_is_store;
    logic                  req_is_word;
    logic                  w_en_raw;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] merged;

    assign accept       = i_valid && o_ready;
    assign fault        = is_misaligned(i_op, i_addr[1:0]);
    assign req_is_store = is_store(req_op);
    assign req_is_word  = (access_size(req_op) == SIZE_WORD);

    // The word address is the latched byte address with the lane bits dropped.
    assign o_mem_addr = {{(DATA_ADDR_WIDTH-30){1'b0}}, req_addr[31:2]};

    mem_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_align (
        .op         (req_op),
        .addr_lo    (req_addr[1:0]),
        .rdata      (i_mem_dout),
        .store_data (req_wdata[15:0]),
        .load_val   (load_val),
        .merged     (merged)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (i_rst) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic: faults never leave IDLE; only sub-word stores visit WRITE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (accept && !fault) state_next = ST_ACCESS;
            ST_ACCESS: state_next = (req_is_store && !req_is_word) ? ST_WRITE : ST_IDLE;
            ST_WRITE:  state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: handshake and memory write port.
    always_comb begin
        o_ready   = (state == ST_IDLE) && !i_rst;
        w_en_raw  = 1'b0;
        o_mem_din = '0;
        case (state)
            ST_ACCESS: begin
                if (req_op == OP_SW) begin
                    w_en_raw  = 1'b1;
                    o_mem_din = req_wdata;
                end
            end
            ST_WRITE: begin
                w_en_raw  = 1'b1;
                o_mem_din = merged_q;
            end
            default: ;
        endcase
        // A reset cycle must never commit a write, even mid-store.
        o_mem_w_en = w_en_raw && !i_rst;
    end

    // Request latch, captured on every accepted request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_op    <= OP_LB;
            req_addr  <= '0;
            req_wdata <= '0;
            req_rd    <= '0;
        end else if (accept) begin
            req_op    <= i_op;
            req_addr  <= i_addr;
            req_wdata <= i_wdata;
            req_rd    <= i_rd;
        end
    end

    // Merged store word, captured during the read half of a sub-word store.
    always_ff @(posedge i_clk) begin
        if (i_rst)                    merged_q <= '0;
        else if (state == ST_ACCESS) merged_q <= merged;
    end

    // Write-back result registers; they hold until the next load completes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_data <= '0;
            o_wb_rd   <= '0;
        end else if (state == ST_ACCESS && !req_is_store) begin
            o_wb_data <= load_val;
            o_wb_rd   <= req_rd;
        end
    end

    // Single-cycle status pulses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_wb_valid <= 1'b0;
            o_done     <= 1'b0;
            o_misalign <= 1'b0;
        end else begin
            o_wb_valid <= (state == ST_ACCESS) && !req_is_store;
            o_done     <= ((state == ST_ACCESS) && (!req_is_store || req_is_word))
                          || (state == ST_WRITE);
            o_misalign <= accept && fault;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage with a behavioural data memory
// and a write-back scoreboard.
module tb_mem_access_stage;
    import mips_mem_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_op = OP_LB;
    logic [31:0] i_addr = '0;
    logic [31:0] i_wdata = '0;
    logic [4:0]  i_rd = '0;
    logic        o_wb_valid;
    logic [31:0] o_wb_data;
    logic [4:0]  o_wb_rd;
    logic        o_done;
    logic        o_misalign;
    logic [31:0] o_mem_addr;
    logic        o_mem_w_en;
    logic [31:0] o_mem_din;
    logic [31:0] i_mem_dout;

    mem_access_stage dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_op       (i_op),
        .i_addr     (i_addr),
        .i_wdata    (i_wdata),
        .i_rd       (i_rd),
        .o_wb_valid (o_wb_valid),
        .o_wb_data  (o_wb_data),
        .o_wb_rd    (o_wb_rd),
        .o_done     (o_done),
        .o_misalign (o_misalign),
        .o_mem_addr (o_mem_addr),
        .o_mem_w_en (o_mem_w_en),
        .o_mem_din  (o_mem_din),
        .i_mem_dout (i_mem_dout)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural data_mem: async read, write on rising edge.
    logic [31:0] mem [0:15];
    assign i_mem_dout = mem[o_mem_addr[3:0]];
    always @(posedge i_clk) if (o_mem_w_en) mem[o_mem_addr[3:0]] <= o_mem_din;

    int edge_cnt = 0;
    always @(posedge i_clk) edge_cnt <= edge_cnt + 1;

    int check_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];
    int      wb_edges[$];
    int      w_en_cnt = 0;

    // Scoreboard side: pop an expectation for every write-back pulse.
    always @(negedge i_clk) begin
        if (o_mem_w_en) w_en_cnt++;
        if (o_wb_valid) begin
            wb_edges.push_back(edge_cnt);
            if (sb.size() == 0) begin
                check("wb_unexpected", 32'(o_wb_valid), 32'd0);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                check("wb_data", o_wb_data, e.data);
                check("wb_rd", 32'(o_wb_rd), 32'(e.rd));
            end
        end
    end

    // Issue one request and follow it to completion, checking the cycle
    // (counted in falling edges after acceptance) of the write and of done.
    task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [4:0] rd, input logic [31:0] exp_data,
                         input int exp_lat, input int exp_wen_at);
        int  waited = 0;
        int  lat = 0;
        int  wen_at = 0;
        bit  fin = 0;
        @(negedge i_clk);
        while (!o_ready && waited < 10) begin
            @(negedge i_clk);
            waited++;
        end
        if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_op    = op;
        i_addr  = addr;
        i_wdata = wdata;
        i_rd    = rd;
        if (!is_store(op)) sb.push_back('{rd: rd, data: exp_data});
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        for (int c = 1; c <= 6 && !fin; c++) begin
            @(negedge i_clk);
            if (o_mem_w_en && wen_at == 0) begin
                wen_at = c;
                check("w_addr", o_mem_addr, addr >> 2);
            end
            if (o_done || o_misalign) begin
                lat = c;
                fin = 1;
            end
        end
        check("done_latency", lat, exp_lat);
        check("write_cycle", wen_at, exp_wen_at);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] snap;
        int          wsnap;

        // Reset state
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("ready_in_reset", 32'(o_ready), 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_wb_valid", 32'(o_wb_valid), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_misalign", 32'(o_misalign), 32'd0);
        check("rst_wb_data", o_wb_data, 32'd0);
        check("rst_wb_rd", 32'(o_wb_rd), 32'd0);
        check("rst_w_en", 32'(o_mem_w_en), 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        check("rst_mem_din", o_mem_din, 32'd0);

        // SW then LW of a full word
        issue(OP_SW, 32'h10, 32'hDEADBEEF, 5'd0, 32'h0, 2, 1);
        check("sw_word", mem[4], 32'hDEADBEEF);
        issue(OP_LW, 32'h10, 32'h0, 5'd3, 32'hDEADBEEF, 2, 0);

        // Byte store / loads on 0x11223344
        issue(OP_SW, 32'h10, 32'h11223344, 5'd0, 32'h0, 2, 1);
        issue(OP_SB, 32'h13, 32'h000000AA, 5'd0, 32'h0, 3, 2);
        check("sb_word", mem[4], 32'hAA223344);
        check("wb_data_hold", o_wb_data, 32'hDEADBEEF);
        issue(OP_LB,  32'h13, 32'h0, 5'd4, 32'hFFFFFFAA, 2, 0);
        issue(OP_LBU, 32'h13, 32'h0, 5'd5, 32'h000000AA, 2, 0);

        // Halfword loads on 0x80017FFF, then sub-word stores in low lanes
        issue(OP_SW,  32'h10, 32'h80017FFF, 5'd0, 32'h0, 2, 1);
        issue(OP_LH,  32'h12, 32'h0, 5'd6, 32'hFFFF8001, 2, 0);
        issue(OP_LHU, 32'h12, 32'h0, 5'd8, 32'h00008001, 2, 0);
        issue(OP_LH,  32'h10, 32'h0, 5'd10, 32'h00007FFF, 2, 0);
        issue(OP_SH,  32'h10, 32'hFFFF1234, 5'd0, 32'h0, 3, 2);
        check("sh_word", mem[4], 32'h80011234);
        issue(OP_SB,  32'h11, 32'h00000055, 5'd0, 32'h0, 3, 2);
        check("sb1_word", mem[4], 32'h80015534);
        issue(OP_LB,  32'h10, 32'h0, 5'd11, 32'h00000034, 2, 0);

        // Back-to-back misaligned requests
        snap  = mem[4];
        wsnap = w_en_cnt;
        @(negedge i_clk);
        i_valid = 1'b1; i_op = OP_LW; i_addr = 32'h11; i_wdata = 32'h0; i_rd = 5'd1;
        @(negedge i_clk);
        check("mis_lw", 32'(o_misalign), 32'd1);
        check("mis_ready", 32'(o_ready), 32'd1);
        i_op = OP_SH; i_addr = 32'h13; i_wdata = 32'hCAFE;
        @(negedge i_clk);
        check("mis_sh", 32'(o_misalign), 32'd1);
        check("mis_no_done", 32'(o_done), 32'd0);
        i_op = OP_SW; i_addr = 32'h12; i_wdata = 32'h01234567;
        @(negedge i_clk);
        check("mis_sw", 32'(o_misalign), 32'd1);
        i_valid = 1'b0;
        @(negedge i_clk);
        check("mis_clear", 32'(o_misalign), 32'd0);
        check("mis_no_write", w_en_cnt, wsnap);
        check("mis_mem", mem[4], snap);

        // Reset during the WRITE cycle of an SH
        snap = mem[4];
        @(negedge i_clk);
        i_valid = 1'b1; i_op = OP_SH; i_addr = 32'h10; i_wdata = 32'h0000BEEF; i_rd = 5'd0;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        check("rmw_write_phase", 32'(o_mem_w_en), 32'd1);
        i_rst = 1'b1;
        #1 check("rst_gates_w_en", 32'(o_mem_w_en), 32'd0);
        @(negedge i_clk);
        check("rst_abort_done", 32'(o_done), 32'd0);
        check("rst_abort_mem", mem[4], snap);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_abort_ready", 32'(o_ready), 32'd1);
        check("rst_abort_done2", 32'(o_done), 32'd0);

        // Back-to-back loads to rd 7 then rd 9
        wb_edges.delete();
        @(negedge i_clk);
        i_valid = 1'b1; i_op = OP_LW; i_addr = 32'h10; i_rd = 5'd7;
        sb.push_back('{rd: 5'd7, data: 32'h80015534});
        @(negedge i_clk);
        check("b2b_busy", 32'(o_ready), 32'd0);
        i_op = OP_LBU; i_addr = 32'h12; i_rd = 5'd9;
        sb.push_back('{rd: 5'd9, data: 32'h00000001});
        @(negedge i_clk);
        check("b2b_ready", 32'(o_ready), 32'd1);
        check("b2b_wb1", 32'(o_wb_valid), 32'd1);
        @(negedge i_clk);
        i_valid = 1'b0;
        for (int c = 0; c < 6 && wb_edges.size() < 2; c++) @(negedge i_clk);
        check("b2b_count", wb_edges.size(), 2);
        if (wb_edges.size() >= 2) check("b2b_spacing", wb_edges[1] - wb_edges[0], 2);

        repeat (2) @(negedge i_clk);
        check("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the MIPS pipeline, sitting directly upstream of `data_mem`. It accepts byte-addressed load/store requests from the execute stage via a valid/ready handshake and converts them into word accesses on `data_mem`'s async-read/sync-write port. Sub-word stores are performed as read-modify-write. Load results are delivered aligned and sign- or zero-extended as a registered write-back result.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data word width; only 32 is supported.
- `DATA_ADDR_WIDTH`, 32, width of the word address driven to `data_mem`.

Ports:
- `i_clk` in 1: clock; all state changes on the rising edge.
- `i_rst` in 1: reset; synchronous, active-high.
- `i_valid` in 1: request valid from execute.
- `o_ready` out 1: stage can accept a request.
- `i_op` in 3: access type. Encoding: LB=000, LH=001, LW=010, SB=011, LBU=100, LHU=101, SH=110, SW=111.
- `i_addr` in 32: byte address.
- `i_wdata` in DATA_WIDTH: store data, right-justified.
- `i_rd` in 5: destination register index, passed through.
- `o_wb_valid` out 1: one-cycle pulse; load result valid.
- `o_wb_data` out DATA_WIDTH: extended load result.
- `o_wb_rd` out 5: destination register of the result.
- `o_done` out 1: one-cycle pulse when any access completes.
- `o_misalign` out 1: one-cycle pulse when an accepted request is misaligned.
- `o_mem_addr` out DATA_ADDR_WIDTH: word address to `data_mem`.
- `o_mem_w_en` out 1: write enable to `data_mem`.
- `o_mem_din` out DATA_WIDTH: write data to `data_mem`.
- `i_mem_dout` in DATA_WIDTH: async read data from `data_mem`.

## Operation
- FSM states: IDLE, ACCESS, WRITE.
- `o_ready` is 1 only in IDLE and while `i_rst` is 0.
- A request is accepted when `i_valid & o_ready`. On acceptance, `op`, `addr`, `wdata` and `rd` are latched.
- Misalignment check at accept:
  - LH, LHU, SH: fault if `addr[0]` = 1.
  - LW, SW: fault if `addr[1:0]` ≠ 0.
  - On a fault: stay in IDLE, pulse `o_misalign` next cycle, make no memory access, assert neither `o_done` nor `o_wb_valid`.
- An aligned request moves the FSM from IDLE to ACCESS.
- `o_mem_addr` = zero-extended latched `addr[31:2]`; it is held constant in ACCESS and WRITE.
- Byte lane mapping is little-endian:
  - byte k is `[8k+7:8k]` with k = `addr[1:0]`.
  - halfword is `[16h+15:16h]` with h = `addr[1]`.
- ACCESS with a load:
  - The lane is extracted from `i_mem_dout`: LB and LH sign-extend, LBU and LHU zero-extend, LW passes the word through.
  - The result is registered into `o_wb_data`/`o_wb_rd`; `o_wb_valid` and `o_done` pulse.
  - FSM → IDLE.
- ACCESS with SW:
  - `o_mem_w_en` = 1 and `o_mem_din` = `wdata`; `o_done` pulses next cycle.
  - FSM → IDLE.
- ACCESS with SB or SH:
  - The merged word (`i_mem_dout` with the target lane replaced by `wdata[7:0]` or `wdata[15:0]`) is registered.
  - FSM → WRITE.
- WRITE: `o_mem_w_en` = 1 and `o_mem_din` = the merged word; `o_done` pulses next cycle; FSM → IDLE.
- `o_mem_w_en` is 0 in IDLE.
- `o_mem_w_en` is combinationally gated by `!i_rst`, so no write occurs in a reset cycle.
- `o_wb_data` and `o_wb_rd` hold their last values until the next load completes.

## Timing
- Reset values:
  - state = IDLE.
  - `o_wb_valid`, `o_done`, `o_misalign` = 0.
  - `o_wb_data` = 0 and `o_wb_rd` = 0.
  - `o_mem_w_en` = 0, `o_mem_addr` = 0, `o_mem_din` = 0.
- Load: accept at edge N; ACCESS during cycle N+1; `o_wb_valid` high in cycle N+2. Issue interval is 2 cycles.
- SW: the write occurs at edge N+2; `o_done` is high in cycle N+2.
- SB/SH: read in cycle N+1; write at edge N+3; `o_done` is high in cycle N+3. Issue interval is 3 cycles.
- Misaligned request: `o_misalign` is high in cycle N+1; `o_ready` stays 1, so back-to-back faults are accepted every cycle.
- Back-to-back requests: a new request can be accepted in the same cycle that `o_wb_valid`/`o_done` is high (the FSM is in IDLE).
- Reset mid-operation: the in-flight access is abandoned; no partial write occurs; no done or valid pulse is produced; the FSM is in IDLE after the reset edge.
- The execute stage must hold `i_valid` and its request fields stable while `o_ready` = 0.

## Structure
- Shared package `mips_mem_pkg`:
  - op encoding constants (`OP_LB` … `OP_SW`).
  - FSM state type.
  - helper functions `is_store(op)` and `access_size(op)`.
- Sub-module `mem_lane_align`:
  - purely combinational.
  - inputs: op, `addr[1:0]`, read word, store data.
  - outputs: extended load value and merged store word.
- The top level holds the FSM, the request latch, the write-back registers and the misalign/done pulse logic.

## Test plan
- SW to `0x10` with data `0xDEADBEEF`, then LW from `0x10` → `o_mem_addr` = 4, write at N+2, load `o_wb_data` = `0xDEADBEEF` at N+2.
- Memory word 4 = `0x11223344`:
  - SB `0x13` with data `0xAA` → word becomes `0xAA223344`; `o_done` at N+3.
  - LB `0x13` → `0xFFFFFFAA`.
  - LBU `0x13` → `0x000000AA`.
- Memory word 4 = `0x8001_7FFF`: LH `0x12` → `0xFFFF8001`; LHU `0x12` → `0x00008001`; LH `0x10` → `0x00007FFF`.
- LW `0x11`, SH `0x13` and SW `0x12` issued back-to-back → `o_misalign` pulses on three consecutive cycles, `o_mem_w_en` never rises, memory is unchanged.
- SH `0x10` with `i_rst` asserted during the WRITE cycle → no write (word is unchanged), `o_done` = 0, `o_ready` = 1 after reset.
- Load to `i_rd` = 7 followed immediately by a load to `i_rd` = 9 → `o_wb_valid` pulses 2 cycles apart with `o_wb_rd` = 7, then 9.
